// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//   Wide unsigned adder that computes {Cout,S} = A + B + Cin one nibble per
//   clock through a single 4-bit adder, with the carry looped through a
//   register. A start/busy/done handshake brackets each operation.
//
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     start  in   operation request, honoured only while busy=0
//     A, B   in   W-bit operands, captured on the accepted start edge
//     Cin    in   carry into nibble 0, captured on the accepted start edge
//     busy   out  high while an operation is in progress
//     done   out  one-cycle pulse when S/Cout are updated
//     S      out  W-bit sum, held until the next completion
//     Cout   out  carry out of the top nibble, held with S
// -----------------------------------------------------------------------------

// 4-bit ripple adder slice shared by every nibble of an operation.
module adder_4b (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);
  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 Cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] S,
  output logic                 Cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int KW = $clog2(NIBBLES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    psum_q, psum_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    s_q, s_d;
  logic            cout_q, cout_d;
  logic            done_q, done_d;

  logic [3:0]      nib_s;
  logic            nib_c;
  logic            accept;
  logic            last;

  // Operand registers shift right each RUN cycle, so the current nibble k is
  // always in bits [3:0] and no wide mux is needed in front of the adder.
  adder_4b u_adder (
    .A    (a_q[3:0]),
    .B    (b_q[3:0]),
    .Cin  (carry_q),
    .S    (nib_s),
    .Cout (nib_c)
  );

  assign accept = (state_q == IDLE) && start;
  assign last   = (state_q == RUN) && (k_q == KW'(NIBBLES - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == RUN);
  end

  // Datapath next-state
  always_comb begin
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    s_d     = s_q;
    cout_d  = cout_q;
    done_d  = 1'b0;

    if (accept) begin
      a_d     = A;
      b_d     = B;
      carry_d = Cin;
      k_d     = '0;
      psum_d  = '0;
    end else if (state_q == RUN) begin
      a_d     = a_q >> 4;
      b_d     = b_q >> 4;
      carry_d = nib_c;
      // Sum nibbles enter at the top and move down; after NIBBLES shifts,
      // nibble 0 sits in bits [3:0].
      psum_d  = {nib_s, psum_q[W-1:4]};
      if (last) begin
        k_d    = '0;
        s_d    = {nib_s, psum_q[W-1:4]};
        cout_d = nib_c;
        done_d = 1'b1;
      end else begin
        k_d    = k_q + KW'(1);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign S    = s_q;
  assign Cout = cout_q;

endmodule
